// File: rtl/lfsr_rng_pkg.sv
// lfsr_rng shared types, tap table and bound-mask helper.
// Optional lock-up recovery macro: LFSR_LOCKUP_RECOVER_EN.
package lfsr_rng_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    SAMPLE = 1'b1
  } draw_state_t;

  localparam logic [63:0] DEFAULT_SEED = 64'h0000_0000_6B1C_CA14;

  // Maximal-length XNOR tap sets, zero-based bit positions.
  function automatic logic [63:0] taps(input int unsigned width);
    logic [63:0] t;
    t = '0;
    case (width)
      8:       t = 64'h0000_0000_0000_00B8;
      16:      t = 64'h0000_0000_0000_D008;
      24:      t = 64'h0000_0000_00E1_0000;
      32:      t = 64'h0000_0000_8020_0003;
      48:      t = 64'h0000_C000_0018_0000;
      64:      t = 64'hD800_0000_0000_0000;
      default: t = '0;
    endcase
    return t;
  endfunction

  function automatic logic [63:0] mask_for(input logic [63:0] bound);
    logic [63:0] m;
    m = '0;
    for (int i = 0; i < 64; i++) begin
      if (m < bound - 64'd1) m = {m[62:0], 1'b1};
    end
    return m;
  endfunction

endpackage

// File: rtl/lfsr_core.sv
// Fibonacci XNOR LFSR register with run/hold, seed load and
// optional all-ones recovery (LFSR_LOCKUP_RECOVER_EN).
module lfsr_core
  import lfsr_rng_pkg::*;
#(
  parameter int unsigned      WIDTH = 32,
  parameter int unsigned      OUT_W = 8,
  parameter logic [WIDTH-1:0] SEED  = DEFAULT_SEED[WIDTH-1:0]
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             RUN,
  input  logic             SEED_LD,
  input  logic [WIDTH-1:0] SEED_IN,
  output logic [OUT_W-1:0] rnd,
  output logic             LOCKUP
);

  localparam logic [63:0] TAPS64 = taps(WIDTH);

  logic [WIDTH-1:0] lfsr_q;
  logic [WIDTH-1:0] nxt;
  logic             fb;

  assign fb  = ~^(lfsr_q & TAPS64[WIDTH-1:0]);
  assign nxt = {lfsr_q[WIDTH-2:0], fb};
  assign rnd = lfsr_q[OUT_W-1:0];

`ifdef LFSR_LOCKUP_RECOVER_EN
  logic lock;
  logic lockup_q;

  assign lock   = &lfsr_q;
  assign LOCKUP = lockup_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)          lfsr_q <= SEED;
    else if (SEED_LD) lfsr_q <= SEED_IN;
    else if (lock)    lfsr_q <= SEED;
    else if (RUN)     lfsr_q <= nxt;
  end

  // Flags the cycle in which the recovered seed is present.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) lockup_q <= 1'b0;
    else     lockup_q <= lock & ~SEED_LD;
  end
`else
  assign LOCKUP = 1'b0;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)          lfsr_q <= SEED;
    else if (SEED_LD) lfsr_q <= SEED_IN;
    else if (RUN)     lfsr_q <= nxt;
  end
`endif

endmodule

// File: rtl/lfsr_rng.sv
// lfsr_rng top: free-running LFSR plus bounded rejection-sampling draw.
// Lock-up recovery is built when LFSR_LOCKUP_RECOVER_EN is defined.
module lfsr_rng
  import lfsr_rng_pkg::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned OUT_W     = 8,
  parameter logic [63:0] SEED      = DEFAULT_SEED,
  parameter int unsigned MAX_TRIES = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             RUN,
  input  logic             SEED_LD,
  input  logic [WIDTH-1:0] SEED_IN,
  output logic [OUT_W-1:0] RANDOM,
  input  logic             REQ,
  input  logic [OUT_W-1:0] BOUND,
  output logic             BUSY,
  output logic             VALID,
  output logic [OUT_W-1:0] RESULT,
  output logic             LOCKUP
);

  localparam int unsigned TW =
    (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
  localparam logic [TW-1:0] LAST = TW'(MAX_TRIES - 1);

  draw_state_t      state_q;
  logic [OUT_W-1:0] bound_q;
  logic [OUT_W-1:0] mask_q;
  logic [TW-1:0]    tries_q;
  logic [OUT_W-1:0] cand;
  logic [OUT_W-1:0] res;
  logic             accept;

  lfsr_core #(
    .WIDTH (WIDTH),
    .OUT_W (OUT_W),
    .SEED  (SEED[WIDTH-1:0])
  ) u_core (
    .CLK     (CLK),
    .RST     (RST),
    .RUN     (RUN),
    .SEED_LD (SEED_LD),
    .SEED_IN (SEED_IN),
    .rnd     (RANDOM),
    .LOCKUP  (LOCKUP)
  );

  assign cand = RANDOM & mask_q;

  // cand < 2*bound_q, so the fallback subtraction stays in range.
  always_comb begin
    accept = 1'b1;
    res    = cand;
    if (bound_q == '0)        res = RANDOM;
    else if (cand < bound_q)  res = cand;
    else if (tries_q == LAST) res = cand - bound_q;
    else                      accept = 1'b0;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      BUSY    <= 1'b0;
      VALID   <= 1'b0;
      RESULT  <= '0;
      bound_q <= '0;
      mask_q  <= '0;
      tries_q <= '0;
    end else begin
      VALID <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (REQ) begin
            bound_q <= BOUND;
            mask_q  <= OUT_W'(mask_for(64'(BOUND)));
            tries_q <= '0;
            BUSY    <= 1'b1;
            state_q <= SAMPLE;
          end
        end
        SAMPLE: begin
          if (accept) begin
            RESULT  <= res;
            VALID   <= 1'b1;
            BUSY    <= 1'b0;
            state_q <= IDLE;
          end else begin
            tries_q <= tries_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lfsr_rng.sv
// Scoreboard bench for lfsr_rng (WIDTH=32, OUT_W=8, MAX_TRIES=8).
// Build with or without LFSR_LOCKUP_RECOVER_EN to match the RTL.
module tb_lfsr_rng;

  localparam logic [31:0] SEED = 32'h6B1C_CA14;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        RUN = 1'b0;
  logic        SEED_LD = 1'b0;
  logic [31:0] SEED_IN = '0;
  logic        REQ = 1'b0;
  logic [7:0]  BOUND = '0;
  logic [7:0]  RANDOM;
  logic [7:0]  RESULT;
  logic        BUSY;
  logic        VALID;
  logic        LOCKUP;

  int tests = 0;
  int fails = 0;

  logic [7:0] exp_q[$];
  logic [7:0] bnd_q[$];
  int         hist[6];
  logic [7:0] mon_e;
  logic [7:0] mon_b;
  logic [31:0] m_lfsr;

  lfsr_rng dut (
    .CLK     (CLK),
    .RST     (RST),
    .RUN     (RUN),
    .SEED_LD (SEED_LD),
    .SEED_IN (SEED_IN),
    .RANDOM  (RANDOM),
    .REQ     (REQ),
    .BOUND   (BOUND),
    .BUSY    (BUSY),
    .VALID   (VALID),
    .RESULT  (RESULT),
    .LOCKUP  (LOCKUP)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Reference LFSR: XNOR of bits 31, 21, 1, 0 shifted in at bit 0.
  function automatic logic [31:0] step(input logic [31:0] l);
    logic f;
    f = ~(l[31] ^ l[21] ^ l[1] ^ l[0]);
    return {l[30:0], f};
  endfunction

  function automatic logic [7:0] predict(input logic [31:0] l0,
                                         input logic run,
                                         input logic [7:0] b);
    logic [31:0] l;
    logic [7:0]  m;
    logic [7:0]  c;
    m = '0;
    while ({1'b0, m} + 9'd1 < {1'b0, b}) m = {m[6:0], 1'b1};
    l = run ? step(l0) : l0;
    for (int t = 0; t < 8; t++) begin
      if (b == 8'd0) return l[7:0];
      c = l[7:0] & m;
      if (c < b) return c;
      if (t == 7) return c - b;
      if (run) l = step(l);
    end
    return 8'd0;
  endfunction

  always @(posedge CLK or posedge RST) begin
    if (RST)          m_lfsr <= SEED;
    else if (SEED_LD) m_lfsr <= SEED_IN;
`ifdef LFSR_LOCKUP_RECOVER_EN
    else if (m_lfsr == 32'hFFFF_FFFF) m_lfsr <= SEED;
`endif
    else if (RUN)     m_lfsr <= step(m_lfsr);
  end

  always @(negedge CLK) begin
    if (!RST && VALID) begin
      check("valid_busy_excl", {63'd0, BUSY}, 64'd0);
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_valid: got RESULT %0h, required no VALID",
                 RESULT);
      end else begin
        mon_e = exp_q.pop_front();
        mon_b = bnd_q.pop_front();
        check("draw_result", RESULT, mon_e);
        if (mon_b != 8'd0)
          check("draw_in_range", {63'd0, RESULT < mon_b}, 64'd1);
        if (mon_b == 8'd6 && RESULT < 8'd6) hist[RESULT]++;
      end
    end
  end

  // Called at a negedge; returns at the negedge where VALID is seen.
  task automatic draw(input logic [7:0] b, input logic [7:0] e,
                      input int lat);
    int n;
    exp_q.push_back(e);
    bnd_q.push_back(b);
    REQ   = 1'b1;
    BOUND = b;
    n     = 0;
    do begin
      @(negedge CLK);
      REQ = 1'b0;
      n++;
    end while (!VALID && n < 40);
    if (!VALID) begin
      tests++;
      fails++;
      $display("FAIL draw_timeout: got no VALID in %0d cycles, required VALID",
               n);
      exp_q.delete();
      bnd_q.delete();
    end else if (lat > 0) begin
      check("draw_latency", 64'(n), 64'(lat));
    end else begin
      check("draw_latency_bound", {63'd0, n >= 2 && n <= 9}, 64'd1);
    end
  endtask

  task automatic load(input logic [31:0] s);
    SEED_LD = 1'b1;
    SEED_IN = s;
    @(negedge CLK);
    SEED_LD = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge CLK);
    check("rst_lfsr", dut.u_core.lfsr_q, SEED);
    check("rst_random", RANDOM, 8'h14);
    check("rst_busy", {63'd0, BUSY}, 64'd0);
    check("rst_valid", {63'd0, VALID}, 64'd0);
    check("rst_result", RESULT, 8'h00);
    check("rst_lockup", {63'd0, LOCKUP}, 64'd0);
    RST = 1'b0;

    RUN = 1'b1;
    @(negedge CLK);
    RUN = 1'b0;
    check("run_step_lfsr", dut.u_core.lfsr_q, 32'hD639_9429);
    check("run_step_random", RANDOM, 8'h29);
    @(negedge CLK);
    check("hold_lfsr", dut.u_core.lfsr_q, 32'hD639_9429);

    load(32'h0000_0001);
    check("seed_ld_norun", dut.u_core.lfsr_q, 32'h0000_0001);
    RUN = 1'b1;
    load(32'h1234_5678);
    RUN = 1'b0;
    check("seed_ld_beats_run", dut.u_core.lfsr_q, 32'h1234_5678);

    // BOUND=1, with a second REQ held through the busy cycle.
    exp_q.push_back(8'd0);
    bnd_q.push_back(8'd1);
    REQ   = 1'b1;
    BOUND = 8'd1;
    @(negedge CLK);
    check("b1_busy_c1", {63'd0, BUSY}, 64'd1);
    check("b1_valid_c1", {63'd0, VALID}, 64'd0);
    @(negedge CLK);
    REQ = 1'b0;
    check("b1_valid_c2", {63'd0, VALID}, 64'd1);
    @(negedge CLK);
    check("b1_req_ignored_busy", {63'd0, BUSY}, 64'd0);
    check("b1_req_ignored_valid", {63'd0, VALID}, 64'd0);

    load(32'h0000_0007);
    draw(8'd5, 8'd2, 9);
    load(32'h0000_0003);
    draw(8'd4, 8'd3, 2);
    load(32'h0000_00A5);
    draw(8'd0, 8'hA5, 2);
    load(32'h0000_00C8);
    draw(8'd200, 8'd0, 9);

    // Seed reloaded mid-draw: 7 rejected, then 3 accepted.
    load(32'h0000_0007);
    exp_q.push_back(8'd3);
    bnd_q.push_back(8'd5);
    REQ   = 1'b1;
    BOUND = 8'd5;
    @(negedge CLK);
    REQ     = 1'b0;
    SEED_LD = 1'b1;
    SEED_IN = 32'h0000_0003;
    @(negedge CLK);
    SEED_LD = 1'b0;
    check("midload_valid_c2", {63'd0, VALID}, 64'd0);
    @(negedge CLK);
    check("midload_valid_c3", {63'd0, VALID}, 64'd1);

    RUN = 1'b1;
    for (int i = 0; i < 2000; i++)
      draw(8'd6, predict(m_lfsr, RUN, 8'd6), 0);
    for (int v = 0; v < 6; v++)
      check("hist_nonzero", {63'd0, hist[v] > 0}, 64'd1);
    check("random_tracks_model", RANDOM, m_lfsr[7:0]);

    load(32'hFFFF_FFFF);
    check("ones_loaded", dut.u_core.lfsr_q, 32'hFFFF_FFFF);
`ifdef LFSR_LOCKUP_RECOVER_EN
    @(negedge CLK);
    check("lockup_recover_lfsr", dut.u_core.lfsr_q, SEED);
    check("lockup_pulse", {63'd0, LOCKUP}, 64'd1);
    @(negedge CLK);
    check("lockup_pulse_end", {63'd0, LOCKUP}, 64'd0);
`else
    repeat (3) @(negedge CLK);
    check("ones_stuck_lfsr", dut.u_core.lfsr_q, 32'hFFFF_FFFF);
    check("ones_no_lockup", {63'd0, LOCKUP}, 64'd0);
`endif

    // Reset during a fallback-length draw; no VALID may follow.
    RUN = 1'b0;
    load(32'h0000_0007);
    REQ   = 1'b1;
    BOUND = 8'd5;
    @(negedge CLK);
    REQ = 1'b0;
    repeat (2) @(negedge CLK);
    check("pre_rst_busy", {63'd0, BUSY}, 64'd1);
    #2 RST = 1'b1;
    #1;
    check("rst_mid_busy", {63'd0, BUSY}, 64'd0);
    check("rst_mid_valid", {63'd0, VALID}, 64'd0);
    @(negedge CLK);
    RST = 1'b0;
    check("rst_mid_lfsr", dut.u_core.lfsr_q, SEED);
    repeat (12) @(negedge CLK);
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
